// File: rtl/regbank_alu_pkg.sv
// rtl/regbank_alu_pkg.sv - shared widths and ALU function encodings for regbank_alu
package regbank_alu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [5:0] FUNCT_ADD   = 6'd0;
    localparam logic [5:0] FUNCT_COMP  = 6'd1;
    localparam logic [5:0] FUNCT_AND   = 6'd2;
    localparam logic [5:0] FUNCT_XOR   = 6'd3;
    localparam logic [5:0] FUNCT_SHLL  = 6'd4;
    localparam logic [5:0] FUNCT_SHRL  = 6'd5;
    localparam logic [5:0] FUNCT_SHLLV = 6'd6;
    localparam logic [5:0] FUNCT_SHRLV = 6'd7;
    localparam logic [5:0] FUNCT_SHRA  = 6'd8;
    localparam logic [5:0] FUNCT_SHRAV = 6'd9;
    localparam logic [5:0] FUNCT_SUB   = 6'd10;
    localparam logic [5:0] FUNCT_OR    = 6'd11;
    localparam logic [5:0] FUNCT_NOR   = 6'd12;
    localparam logic [5:0] FUNCT_SLT   = 6'd13;

endpackage

// File: rtl/regbank_alu_alu.sv
// rtl/regbank_alu_alu.sv - registered 32-bit integer ALU (one-cycle latency)
module regbank_alu_alu
    import regbank_alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic [4:0]               shamt,
    input  logic [5:0]               funct,
    output logic signed [DATA_W-1:0] out
);

    logic signed [DATA_W-1:0] alu_d;
    logic signed [DATA_W-1:0] alu_q;

    // Operation select; a and b are signed so >>> and < are arithmetic/signed
    always_comb begin
        alu_d = '0;
        case (funct)
            FUNCT_ADD:   alu_d = a + b;
            FUNCT_COMP:  alu_d = -b;
            FUNCT_AND:   alu_d = a & b;
            FUNCT_XOR:   alu_d = a ^ b;
            FUNCT_SHLL:  alu_d = a << shamt;
            FUNCT_SHRL:  alu_d = a >> shamt;
            FUNCT_SHLLV: alu_d = a << b[4:0];
            FUNCT_SHRLV: alu_d = a >> b[4:0];
            FUNCT_SHRA:  alu_d = a >>> shamt;
            FUNCT_SHRAV: alu_d = a >>> b[4:0];
            FUNCT_SUB:   alu_d = a - b;
            FUNCT_OR:    alu_d = a | b;
            FUNCT_NOR:   alu_d = ~(a | b);
            FUNCT_SLT:   alu_d = (a < b) ? DATA_W'(1) : '0;
            default:     alu_d = '0;
        endcase
    end

    // Result register; reset drops any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_d;
        end
    end

    assign out = alu_q;

endmodule

// File: rtl/regbank_alu.sv
// rtl/regbank_alu.sv - 32x32 register file with registered ALU writeback; REGBANK_BYPASS_EN enables write-through forwarding
module regbank_alu
    import regbank_alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        sr1,
    input  logic [ADDR_W-1:0]        sr2,
    input  logic [ADDR_W-1:0]        dr,
    input  logic                     write,
    input  logic [4:0]               shamt,
    input  logic [5:0]               funct,
    output logic signed [DATA_W-1:0] rData1,
    output logic signed [DATA_W-1:0] rData2,
    output logic signed [DATA_W-1:0] ALUout
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic signed [DATA_W-1:0] alu_out;
    logic wr_en;

    assign wr_en = write && (dr != '0);

    // Read ports; register 0 is hard-wired to zero, forwarding optional
    always_comb begin
        rData1 = (sr1 == '0) ? '0 : regs_q[sr1];
        rData2 = (sr2 == '0) ? '0 : regs_q[sr2];
`ifdef REGBANK_BYPASS_EN
        if (wr_en && (sr1 == dr)) begin
            rData1 = alu_out;
        end
        if (wr_en && (sr2 == dr)) begin
            rData2 = alu_out;
        end
`endif
    end

    // Writeback takes the pre-edge ALU result; writes to r0 are dropped
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[dr] = alu_out;
        end
    end

    // Register array state; reset has priority over a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regbank_alu_alu u_alu (
        .clk   (clk),
        .reset (reset),
        .a     (rData1),
        .b     (rData2),
        .shamt (shamt),
        .funct (funct),
        .out   (alu_out)
    );

    assign ALUout = alu_out;

endmodule

// File: tb/tb_regbank_alu.sv
// tb/tb_regbank_alu.sv - scoreboard bench for regbank_alu against a behavioural model
module tb_regbank_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  sr1, sr2, dr;
    logic        write;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic signed [31:0] rData1, rData2, ALUout;

    regbank_alu dut (
        .clk    (clk),
        .reset  (reset),
        .sr1    (sr1),
        .sr2    (sr2),
        .dr     (dr),
        .write  (write),
        .shamt  (shamt),
        .funct  (funct),
        .rData1 (rData1),
        .rData2 (rData2),
        .ALUout (ALUout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] alu;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   stim_done = 1'b0;
    int   total = 0;
    int   bad = 0;

    // reference state
    bit [31:0] m_regs [32];
    bit [31:0] m_alu;
    int        n_step = 0;

    function automatic bit [31:0] ref_op(bit [31:0] a, bit [31:0] b, int sh, int fn);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (fn)
            0:  return a + b;
            1:  return 32'd0 - b;
            2:  return a & b;
            3:  return a ^ b;
            4:  return a << sh;
            5:  return a >> sh;
            6:  return a << (b % 32);
            7:  return a >> (b % 32);
            8:  return sa >>> sh;
            9:  return sa >>> (b % 32);
            10: return a - b;
            11: return a | b;
            12: return ~(a | b);
            13: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one cycle of inputs, record what the DUT must show before the next edge,
    // then advance the model across that edge.
    task automatic step(input bit rst, input int s1, input int s2, input int d,
                        input bit wr, input int sh, input int fn);
        exp_t e;
        bit [31:0] a, b;
        reset = rst;
        sr1 = 5'(s1);
        sr2 = 5'(s2);
        dr = 5'(d);
        write = wr;
        shamt = 5'(sh);
        funct = 6'(fn);
        a = (s1 == 0) ? 32'd0 : m_regs[s1];
        b = (s2 == 0) ? 32'd0 : m_regs[s2];
`ifdef REGBANK_BYPASS_EN
        if (wr && d != 0 && s1 == d) a = m_alu;
        if (wr && d != 0 && s2 == d) b = m_alu;
`endif
        e.rd1 = a;
        e.rd2 = b;
        e.alu = m_alu;
        e.cyc = n_step;
        exp_q.push_back(e);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_alu = 32'd0;
        end else begin
            if (wr && d != 0) m_regs[d] = m_alu;
            m_alu = ref_op(a, b, sh, fn);
        end
        n_step++;
        @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        int f;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_alu = 32'd0;
        reset = 1'b1; sr1 = 0; sr2 = 0; dr = 0; write = 0; shamt = 0; funct = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset state and read sweep
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) step(0, i, 31 - i, 0, 0, 0, 0);
        // seed reg1 with NOR of zeros
        step(0, 0, 0, 0, 0, 0, 12);
        step(0, 0, 0, 1, 1, 0, 12);
        // ADD, write reg2, COMP
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 2, 1, 0, 0);
        step(0, 1, 2, 0, 0, 0, 1);
        // logical and arithmetic shifts, shamt 0 passthrough
        step(0, 1, 0, 0, 0, 28, 5);
        step(0, 2, 0, 0, 0, 4, 8);
        step(0, 2, 0, 0, 0, 0, 4);
        step(0, 1, 2, 0, 0, 0, 13);
        step(0, 2, 1, 0, 0, 0, 13);
        // r0 write discarded, illegal funct
        step(0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 20);
        step(0, 0, 0, 0, 0, 0, 63);
        // same-cycle read of the written register
        step(0, 1, 1, 0, 0, 0, 10);
        step(0, 3, 3, 3, 1, 0, 11);
        step(0, 3, 3, 0, 0, 0, 0);
        // reset priority over write
        step(1, 3, 1, 5, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, i, i, 0, 0, 0, 0);
        // random traffic, rebuild contents with seeded NOR first
        step(0, 0, 0, 0, 0, 0, 12);
        for (int n = 0; n < 1500; n++) begin
            f = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 63) : $urandom_range(0, 13);
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 2) != 0, $urandom_range(0, 31), f);
        end
        stim_done = 1'b1;
    end

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        int   waited;
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (rData1 !== e.rd1) begin
                    bad++;
                    $display("FAIL rdata1 step=%0d got=%h want=%h", e.cyc, rData1, e.rd1);
                end
                total++;
                if (rData2 !== e.rd2) begin
                    bad++;
                    $display("FAIL rdata2 step=%0d got=%h want=%h", e.cyc, rData2, e.rd2);
                end
                total++;
                if (ALUout !== e.alu) begin
                    bad++;
                    $display("FAIL aluout step=%0d got=%h want=%h", e.cyc, ALUout, e.alu);
                end
            end else if (stim_done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (waited > 20000) begin
                total++;
                bad++;
                $display("FAIL timeout cycles=%0d got=running want=done", waited);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule
